// File: rtl/n64_pi_pkg.sv
// Shared types and constants for the N64 PI cartridge read sequencer.
`timescale 1ns/1ps
package n64_pi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L,
        FETCH,
        READY,
        SERVE
    } state_t;

    localparam int AD_W      = 16;
    localparam int PI_ADDR_W = 32;
    localparam int ADDR_STEP = 2;

endpackage

// File: rtl/n64_pi_sync.sv
// Multi-flop synchroniser for async N64 bus pins, preset high (idle bus),
// with optional registered previous value and rise/fall detection.
`timescale 1ns/1ps
module n64_pi_sync #(
    parameter int W      = 1,
    parameter int STAGES = 2,
    parameter bit EDGES  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic [W-1:0] o_rise,
    output logic [W-1:0] o_fall
);

    logic [STAGES-1:0][W-1:0] r_pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pipe <= '1;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign o_q = r_pipe[STAGES-1];

    generate
        if (EDGES) begin : g_edge
            logic [W-1:0] r_prev;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_prev <= '1;
                else     r_prev <= o_q;
            end
            assign o_rise = ~r_prev & o_q;
            assign o_fall = r_prev & ~o_q;
        end else begin : g_noedge
            assign o_rise = '0;
            assign o_fall = '0;
        end
    endgenerate

endmodule

// File: rtl/n64_pi_read_sequencer.sv
// N64 PI cartridge read sequencer: latches the ALE address, fetches words from
// backing memory and serves them per READ_N pulse. Optional N64_PI_PREFETCH_EN.
`timescale 1ns/1ps
module n64_pi_read_sequencer
    import n64_pi_pkg::*;
#(
    parameter int ADDR_W      = 26,
    parameter int SYNC_STAGES = 2,
    parameter int UNDER_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [AD_W-1:0]    n64_ad_i,
    output logic [AD_W-1:0]    n64_ad_o,
    output logic               n64_ad_oe,
    input  logic               n64_read_n,
    input  logic               n64_ale_h,
    input  logic               n64_ale_l,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [AD_W-1:0]    mem_rdata,
    output logic               busy,
    output logic [UNDER_W-1:0] underrun_cnt
);

    logic [2:0]      w_rise, w_fall;
    logic [AD_W-1:0] w_ad;

    // bit0 read_n, bit1 ale_h, bit2 ale_l
    n64_pi_sync #(.W(3), .STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_strb (
        .clk(clk), .rst(reset), .i_d({n64_ale_l, n64_ale_h, n64_read_n}),
        .o_q(), .o_rise(w_rise), .o_fall(w_fall)
    );

    n64_pi_sync #(.W(AD_W), .STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_ad (
        .clk(clk), .rst(reset), .i_d(n64_ad_i),
        .o_q(w_ad), .o_rise(), .o_fall()
    );

    wire w_rd_fall   = w_fall[0];
    wire w_rd_rise   = w_rise[0];
    wire w_aleh_fall = w_fall[1];
    wire w_alel_fall = w_fall[2];

    state_t               r_state;
    logic [PI_ADDR_W-1:0] r_addr;
    logic [AD_W-1:0]      r_dbuf, r_ad_o;
    logic                 r_ad_oe, r_mem_req, r_discard, r_under_hit;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [UNDER_W-1:0]   r_under_cnt;
`ifdef N64_PI_PREFETCH_EN
    logic [AD_W-1:0]      r_pbuf;
    logic                 r_pvld;
`endif

    // Data of an aborted request must be dropped, hence the discard qualifier.
    wire w_ack_ok = r_mem_req & mem_ack & ~r_discard;
    wire [PI_ADDR_W-1:0] w_addr_inc =
        {r_addr[PI_ADDR_W-1:ADDR_W], r_addr[ADDR_W-1:0] + ADDR_W'(ADDR_STEP)};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_dbuf      <= '0;
            r_ad_o      <= '0;
            r_ad_oe     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_discard   <= 1'b0;
            r_under_hit <= 1'b0;
            r_under_cnt <= '0;
`ifdef N64_PI_PREFETCH_EN
            r_pbuf      <= '0;
            r_pvld      <= 1'b0;
`endif
        end else begin
            if (r_mem_req && mem_ack) begin
                r_mem_req <= 1'b0;
                r_discard <= 1'b0;
            end
            if (w_rd_fall && r_state == FETCH && !(&r_under_cnt))
                r_under_cnt <= r_under_cnt + 1'b1;

            if (w_aleh_fall && r_state != IDLE) begin
                r_ad_oe          <= 1'b0;
                r_addr[31:16]    <= w_ad;
                r_state          <= WAIT_L;
                if (r_mem_req && !mem_ack) r_discard <= 1'b1;
`ifdef N64_PI_PREFETCH_EN
                r_pvld           <= 1'b0;
`endif
            end else begin
                case (r_state)
                    IDLE: if (w_aleh_fall) begin
                        r_addr[31:16] <= w_ad;
                        r_state       <= WAIT_L;
                    end
                    WAIT_L: if (w_alel_fall) begin
                        r_addr[15:0]  <= {w_ad[15:1], 1'b0};
                        r_under_hit   <= 1'b0;
                        r_state       <= FETCH;
                    end
                    FETCH: begin
                        if (w_rd_fall) r_under_hit <= 1'b1;
                        if (!r_mem_req) begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_addr[ADDR_W-1:0];
                        end else if (w_ack_ok) begin
                            r_dbuf <= mem_rdata;
                            if (r_under_hit || w_rd_fall) begin
                                r_ad_o  <= mem_rdata;
                                r_ad_oe <= 1'b1;
                                r_state <= SERVE;
                            end else begin
                                r_state <= READY;
                            end
                        end
                    end
                    READY: if (w_rd_fall) begin
                        r_ad_o  <= r_dbuf;
                        r_ad_oe <= 1'b1;
                        r_state <= SERVE;
                    end
                    SERVE: if (w_rd_rise) begin
                        r_ad_oe <= 1'b0;
                        r_addr  <= w_addr_inc;
`ifdef N64_PI_PREFETCH_EN
                        if (r_pvld || w_ack_ok) begin
                            r_dbuf  <= r_pvld ? r_pbuf : mem_rdata;
                            r_pvld  <= 1'b0;
                            r_state <= READY;
                        end else begin
                            r_under_hit <= 1'b0;
                            r_state     <= FETCH;
                        end
`else
                        r_under_hit <= 1'b0;
                        r_state     <= FETCH;
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end

`ifdef N64_PI_PREFETCH_EN
            // Keep the next word in flight while the current one is held/served.
            if (!w_aleh_fall && (r_state == READY || r_state == SERVE)) begin
                if (!r_mem_req && !r_pvld) begin
                    r_mem_req  <= 1'b1;
                    r_mem_addr <= w_addr_inc[ADDR_W-1:0];
                end else if (w_ack_ok && !(r_state == SERVE && w_rd_rise)) begin
                    r_pbuf <= mem_rdata;
                    r_pvld <= 1'b1;
                end
            end
`endif
        end
    end

    assign n64_ad_o     = r_ad_o;
    assign n64_ad_oe    = r_ad_oe;
    assign mem_req      = r_mem_req;
    assign mem_addr     = r_mem_addr;
    assign busy         = (r_state != IDLE);
    assign underrun_cnt = r_under_cnt;

endmodule

// File: tb/tb_n64_pi_read_sequencer.sv
// Directed self-checking bench for n64_pi_read_sequencer with a delayed-ack memory model.
`timescale 1ns/1ps
module tb_n64_pi_read_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] n64_ad_i = 16'h0000;
    logic [15:0] n64_ad_o;
    logic        n64_ad_oe;
    logic        n64_read_n = 1'b1;
    logic        n64_ale_h = 1'b1;
    logic        n64_ale_l = 1'b1;
    logic        mem_req;
    logic [25:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [7:0]  underrun_cnt;

    int n_chk = 0;
    int n_fail = 0;
    int mem_delay = 3;
    int mem_cnt;
    int drop_err = 0;
    int oe_seen = 0;
    bit watch_oe = 1'b0;
    logic prev_req = 1'b0;
    logic prev_ack = 1'b0;

    n64_pi_read_sequencer dut (
        .clk(clk), .reset(reset),
        .n64_ad_i(n64_ad_i), .n64_ad_o(n64_ad_o), .n64_ad_oe(n64_ad_oe),
        .n64_read_n(n64_read_n), .n64_ale_h(n64_ale_h), .n64_ale_l(n64_ale_l),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .underrun_cnt(underrun_cnt)
    );

    always #1 clk = ~clk;

    // Memory: rdata = addr[16:1], ack after mem_delay clocks of request.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 16'h0;
            mem_cnt   <= 0;
        end else begin
            mem_ack <= 1'b0;
            if (mem_req && !mem_ack) begin
                if (mem_cnt >= mem_delay - 1) begin
                    mem_ack   <= 1'b1;
                    mem_rdata <= mem_addr[16:1];
                    mem_cnt   <= 0;
                end else begin
                    mem_cnt <= mem_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && prev_req && !mem_req && !prev_ack) drop_err <= drop_err + 1;
        prev_req <= mem_req;
        prev_ack <= mem_ack;
        if (watch_oe && n64_ad_oe) oe_seen <= oe_seen + 1;
    end

    task automatic pi_addr(input logic [31:0] a);
        n64_ale_l = 1'b1;
        n64_ale_h = 1'b1;
        n64_ad_i  = a[31:16];
        #10 n64_ale_h = 1'b0;
        #10 n64_ad_i  = a[15:0];
        #10 n64_ale_l = 1'b0;
    endtask

    task automatic pi_read(output logic [15:0] d, output logic oe);
        n64_read_n = 1'b0;
        #20;
        oe = n64_ad_oe;
        d  = n64_ad_o;
        #10 n64_read_n = 1'b1;
        #30;
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (mem_req === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (mem_ack === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #10 reset = 1'b0;
        #4;
        n_chk++; if (n64_ad_o !== 16'h0) begin n_fail++; $display("FAIL rst_ad_o: got %h want 0000", n64_ad_o); end
        n_chk++; if (n64_ad_oe !== 1'b0) begin n_fail++; $display("FAIL rst_ad_oe: got %b want 0", n64_ad_oe); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        n_chk++; if (mem_addr !== 26'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (underrun_cnt !== 8'h0) begin n_fail++; $display("FAIL rst_underrun: got %h want 00", underrun_cnt); end
    endtask

    task automatic test_ignore_idle();
        n64_read_n = 1'b0;
        #10;
        n_chk++; if (n64_ad_oe !== 1'b0) begin n_fail++; $display("FAIL idle_read_oe: got %b want 0", n64_ad_oe); end
        n64_read_n = 1'b1;
        n64_ale_l  = 1'b0;
        #10;
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_alel_busy: got %b want 0", busy); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL idle_alel_req: got %b want 0", mem_req); end
        n64_ale_l = 1'b1;
        #10;
    endtask

    task automatic test_single();
        logic [15:0] d; logic oe; bit ok;
        pi_addr(32'h1000_0040);
        wait_req(ok);
        n_chk++; if (!ok || mem_addr !== 26'h0000040) begin n_fail++; $display("FAIL t1_mem_addr: got %h (req seen %0d) want 0000040", mem_addr, ok); end
        #40;
        pi_read(d, oe);
        n_chk++; if (oe !== 1'b1 || d !== 16'h0020) begin n_fail++; $display("FAIL t1_ad: got oe=%b ad=%h want oe=1 ad=0020", oe, d); end
        n_chk++; if (underrun_cnt !== 8'h0) begin n_fail++; $display("FAIL t1_underrun: got %h want 00", underrun_cnt); end
    endtask

    task automatic test_burst();
        logic [15:0] d; logic oe; logic [25:0] exp_a;
        pi_addr(32'h1000_0040);
        #40;
        for (int i = 0; i < 4; i++) begin
            pi_read(d, oe);
            n_chk++; if (oe !== 1'b1 || d !== 16'h0020 + 16'(i)) begin n_fail++; $display("FAIL t2_word%0d: got oe=%b ad=%h want oe=1 ad=%h", i, oe, d, 16'h0020 + 16'(i)); end
        end
`ifdef N64_PI_PREFETCH_EN
        exp_a = 26'h000004A;
`else
        exp_a = 26'h0000048;
`endif
        n_chk++; if (mem_addr !== exp_a) begin n_fail++; $display("FAIL t2_final_addr: got %h want %h", mem_addr, exp_a); end
        n_chk++; if (underrun_cnt !== 8'h0) begin n_fail++; $display("FAIL t2_underrun: got %h want 00", underrun_cnt); end
    endtask

    task automatic test_underrun();
        bit ok;
        mem_delay = 20;
        pi_addr(32'h1000_0100);
        #2 n64_read_n = 1'b0;
        wait_ack(ok);
        n_chk++; if (!ok || n64_ad_oe !== 1'b0) begin n_fail++; $display("FAIL t3_oe_at_ack: got oe=%b (ack seen %0d) want 0", n64_ad_oe, ok); end
        @(negedge clk);
        n_chk++; if (n64_ad_oe !== 1'b1 || n64_ad_o !== 16'h0080) begin n_fail++; $display("FAIL t3_oe_after_ack: got oe=%b ad=%h want oe=1 ad=0080", n64_ad_oe, n64_ad_o); end
        n_chk++; if (underrun_cnt !== 8'h1) begin n_fail++; $display("FAIL t3_underrun: got %h want 01", underrun_cnt); end
        mem_delay = 3;
        #10 n64_read_n = 1'b1;
        #60;
    endtask

    task automatic test_abort();
        logic [15:0] d; logic oe; bit ok;
        mem_delay = 20;
        pi_addr(32'h1000_0200);
        wait_req(ok);
        n_chk++; if (!ok || mem_addr !== 26'h0000200) begin n_fail++; $display("FAIL t4_first_req: got %h (req seen %0d) want 0000200", mem_addr, ok); end
        watch_oe  = 1'b1;
        n64_ale_l = 1'b1;
        n64_ale_h = 1'b1;
        n64_ad_i  = 16'h1000;
        #4 n64_ale_h = 1'b0;
        #6 n64_ad_i  = 16'h0300;
        #6 n64_ale_l = 1'b0;
        wait_ack(ok);
        n_chk++; if (!ok || mem_addr !== 26'h0000200) begin n_fail++; $display("FAIL t4_held_addr: got %h (ack seen %0d) want 0000200", mem_addr, ok); end
        @(negedge clk);
        wait_req(ok);
        n_chk++; if (!ok || mem_addr !== 26'h0000300) begin n_fail++; $display("FAIL t4_new_req: got %h (req seen %0d) want 0000300", mem_addr, ok); end
        mem_delay = 3;
        #60;
        watch_oe = 1'b0;
        n_chk++; if (oe_seen != 0) begin n_fail++; $display("FAIL t4_stale_drive: got %0d oe cycles want 0", oe_seen); end
        pi_read(d, oe);
        n_chk++; if (oe !== 1'b1 || d !== 16'h0180) begin n_fail++; $display("FAIL t4_new_word: got oe=%b ad=%h want oe=1 ad=0180", oe, d); end
        n_chk++; if (drop_err != 0) begin n_fail++; $display("FAIL t4_req_drop: got %0d early drops want 0", drop_err); end
    endtask

    task automatic test_wrap();
        logic [15:0] d; logic oe; bit ok; logic [25:0] exp_a;
        pi_addr(32'h13FF_FFFE);
        wait_req(ok);
        n_chk++; if (!ok || mem_addr !== 26'h3FFFFFE) begin n_fail++; $display("FAIL t5_first_addr: got %h (req seen %0d) want 3fffffe", mem_addr, ok); end
        #40;
        pi_read(d, oe);
        n_chk++; if (oe !== 1'b1 || d !== 16'hFFFF) begin n_fail++; $display("FAIL t5_word0: got oe=%b ad=%h want oe=1 ad=ffff", oe, d); end
`ifdef N64_PI_PREFETCH_EN
        exp_a = 26'h0000002;
`else
        exp_a = 26'h0000000;
`endif
        n_chk++; if (mem_addr !== exp_a) begin n_fail++; $display("FAIL t5_wrap_addr: got %h want %h", mem_addr, exp_a); end
        pi_read(d, oe);
        n_chk++; if (oe !== 1'b1 || d !== 16'h0000) begin n_fail++; $display("FAIL t5_word1: got oe=%b ad=%h want oe=1 ad=0000", oe, d); end
    endtask

    task automatic test_reset_mid();
        pi_addr(32'h1000_0040);
        #40;
        n64_read_n = 1'b0;
        #12;
        n_chk++; if (n64_ad_oe !== 1'b1) begin n_fail++; $display("FAIL t6_serving: got oe=%b want 1", n64_ad_oe); end
        reset = 1'b1;
        #0.5;
        n_chk++; if (n64_ad_oe !== 1'b0) begin n_fail++; $display("FAIL t6_async_oe: got %b want 0", n64_ad_oe); end
        n_chk++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL t6_async_req: got %b want 0", mem_req); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_async_busy: got %b want 0", busy); end
        n_chk++; if (underrun_cnt !== 8'h0) begin n_fail++; $display("FAIL t6_async_underrun: got %h want 00", underrun_cnt); end
        #1.5;
        n64_read_n = 1'b1;
        n64_ale_h  = 1'b1;
        n64_ale_l  = 1'b1;
        #4 reset = 1'b0;
        #10;
    endtask

    initial begin
        test_reset();
        test_ignore_idle();
        test_single();
        test_burst();
        test_underrun();
        test_abort();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
